// File: rtl/axi4_slave_pkg.sv
// rtl/axi4_slave_pkg.sv - shared types and beat-address helper for the AXI4 slave read path
package axi4_slave_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_t;

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_BURST = 2'd1,
    RD_DRAIN = 2'd2
  } rd_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Computed at 64 bits; callers truncate to their address width, which gives the INCR wrap-around.
  function automatic logic [63:0] next_beat_addr(input logic [63:0] addr, input logic [2:0] size,
                                                 input logic [15:0] len, input burst_t burst);
    logic [63:0] bytes;
    logic [63:0] mask;
    logic [63:0] nxt;
    bytes = 64'd1 << size;
    mask  = ((64'(len) + 64'd1) << size) - 64'd1;
    case (burst)
      BURST_FIXED: nxt = addr;
      BURST_WRAP:  nxt = (addr & ~mask) | ((addr + bytes) & mask);
      default:     nxt = (addr & ~(bytes - 64'd1)) + bytes;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/axi4_rd_beat_fifo.sv
// rtl/axi4_rd_beat_fifo.sv - two-entry R beat buffer {data,resp,last} with registered head
module axi4_rd_beat_fifo #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic [1:0]            push_resp,
  input  logic                  push_last,
  input  logic                  pop,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data,
  output logic [1:0]            resp,
  output logic                  last,
  output logic [1:0]            count
);

  localparam int W = DATA_WIDTH + 3;

  logic [W-1:0] head;
  logic [W-1:0] tail;
  logic [W-1:0] din;
  logic         do_pop;
  logic         do_push;

  assign din     = {push_data, push_resp, push_last};
  assign do_pop  = pop && (count != 2'd0);
  // Push while full is only taken together with a pop; the credit scheme upstream keeps it that way.
  assign do_push = push && ((count != 2'd2) || do_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= 2'd0;
    end else begin
      if (do_pop) begin
        if (count == 2'd2) head <= tail;
        else if (do_push) head <= din;
        if ((count == 2'd2) && do_push) tail <= din;
      end else if (do_push) begin
        if (count == 2'd0) head <= din;
        else tail <= din;
      end
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign valid = (count != 2'd0);
  assign data  = head[W-1:3];
  assign resp  = head[2:1];
  assign last  = head[0];

endmodule

// File: rtl/axi4_slave_read_sequencer.sv
// rtl/axi4_slave_read_sequencer.sv - AXI4 slave read burst sequencer over a 1-cycle memory port
// Optional AXI4_RD_SEQ_SLVERR_EN: flags illegal bursts and out-of-range beats with SLVERR.
module axi4_slave_read_sequencer
  import axi4_slave_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int LEN_WIDTH  = 8,
  parameter int MEM_BYTES  = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  arvalid,
  output logic                  arready,
  input  logic [ADDR_WIDTH-1:0] araddr,
  input  logic [ID_WIDTH-1:0]   arid,
  input  logic [LEN_WIDTH-1:0]  arlen,
  input  logic [2:0]            arsize,
  input  logic [1:0]            arburst,
  output logic                  rvalid,
  input  logic                  rready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [ID_WIDTH-1:0]   rid,
  output logic [1:0]            rresp,
  output logic                  rlast,
  output logic                  mem_re,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy
);

  rd_state_t             state;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [ID_WIDTH-1:0]   cap_id;
  logic [LEN_WIDTH-1:0]  cap_len;
  logic [LEN_WIDTH-1:0]  issue_cnt;
  logic [2:0]            cap_size;
  burst_t                cap_burst;
  logic                  inflight;
  logic                  inflight_err;
  logic                  inflight_last;
  logic [1:0]            fifo_count;
  logic                  capture;
  logic                  pop;
  logic                  issue;
  logic                  beat_err;
  logic [DATA_WIDTH-1:0] push_data;
  logic [1:0]            push_resp;

  assign capture = arvalid && arready;
  assign pop     = rvalid && rready;
  // credit = 2 - (fifo_count + inflight) + pop, issue while credit > 0
  assign issue   = (state == RD_BURST) &&
                   (({1'b0, fifo_count} + {2'b0, inflight}) < (3'd2 + {2'b0, pop}));

`ifdef AXI4_RD_SEQ_SLVERR_EN
  localparam logic [2:0]          MAX_SIZE  = 3'($clog2(DATA_WIDTH / 8));
  localparam logic [ADDR_WIDTH:0] MEM_LIMIT = (ADDR_WIDTH + 1)'(MEM_BYTES);

  logic ar_err;
  logic burst_err;

  assign ar_err = (arburst == BURST_RSVD) ||
                  ((arburst == BURST_WRAP) &&
                   !((arlen == LEN_WIDTH'(1)) || (arlen == LEN_WIDTH'(3)) ||
                     (arlen == LEN_WIDTH'(7)) || (arlen == LEN_WIDTH'(15)))) ||
                  (arsize > MAX_SIZE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) burst_err <= 1'b0;
    else if (capture) burst_err <= ar_err;
  end

  assign beat_err = burst_err || ({1'b0, cur_addr} >= MEM_LIMIT);
`else
  assign beat_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= RD_IDLE;
      arready       <= 1'b0;
      cur_addr      <= '0;
      cap_id        <= '0;
      cap_len       <= '0;
      cap_size      <= 3'd0;
      cap_burst     <= BURST_FIXED;
      issue_cnt     <= '0;
      inflight      <= 1'b0;
      inflight_err  <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight      <= issue;
      inflight_err  <= beat_err;
      inflight_last <= (issue_cnt == cap_len);
      case (state)
        RD_IDLE: begin
          arready <= 1'b1;
          if (capture) begin
            cur_addr  <= araddr;
            cap_id    <= arid;
            cap_len   <= arlen;
            cap_size  <= arsize;
            cap_burst <= burst_t'(arburst);
            issue_cnt <= '0;
            arready   <= 1'b0;
            state     <= RD_BURST;
          end
        end
        RD_BURST: begin
          if (issue) begin
            cur_addr  <= ADDR_WIDTH'(next_beat_addr(64'(cur_addr), cap_size, 16'(cap_len), cap_burst));
            issue_cnt <= issue_cnt + LEN_WIDTH'(1);
            if (issue_cnt == cap_len) state <= RD_DRAIN;
          end
        end
        RD_DRAIN: begin
          if (pop && rlast) begin
            state   <= RD_IDLE;
            arready <= 1'b1;
          end
        end
        default: state <= RD_IDLE;
      endcase
    end
  end

  // Erroneous beats still occupy a slot so beat count and timing match a normal burst.
  assign push_data = inflight_err ? '0 : mem_rdata;
  assign push_resp = inflight_err ? RESP_SLVERR : RESP_OKAY;

  axi4_rd_beat_fifo #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (inflight),
    .push_data(push_data),
    .push_resp(push_resp),
    .push_last(inflight_last),
    .pop      (pop),
    .valid    (rvalid),
    .data     (rdata),
    .resp     (rresp),
    .last     (rlast),
    .count    (fifo_count)
  );

  assign mem_re   = issue && !beat_err;
  assign mem_addr = cur_addr;
  assign rid      = cap_id;
  assign busy     = (state != RD_IDLE);

endmodule

// File: tb/tb_axi4_slave_read_sequencer.sv
// tb/tb_axi4_slave_read_sequencer.sv - scoreboard bench for axi4_slave_read_sequencer
module tb_axi4_slave_read_sequencer;

  localparam int MB = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] araddr = '0;
  logic [3:0]  arid = '0;
  logic [7:0]  arlen = '0;
  logic [2:0]  arsize = '0;
  logic [1:0]  arburst = '0;
  logic        rvalid;
  logic        rready = 1'b0;
  logic [31:0] rdata;
  logic [3:0]  rid;
  logic [1:0]  rresp;
  logic        rlast;
  logic        mem_re;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata = '0;
  logic        busy;

  axi4_slave_read_sequencer #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4), .LEN_WIDTH(8), .MEM_BYTES(MB)
  ) dut (
    .clk(clk), .rst(rst), .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .arid(arid), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rid(rid), .rresp(rresp), .rlast(rlast),
    .mem_re(mem_re), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  id;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  beat_t       exp_q[$];
  logic [31:0] addr_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int hs_cyc = 0;
  int mre_cnt = 0;
  bit want_lat = 0;
  bit lat_chk = 0;
  bit arr_chk = 0;
  bit rnd_rdy = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_re) mem_rdata <= mem_word(mem_addr);
    else mem_rdata <= 32'hDEAD_BEEF;
  end

  function automatic logic [31:0] beat_addr(input logic [31:0] start, input int size, input int len,
                                            input int burst, input int i);
    logic [31:0] bytes, total, al, lower;
    bytes = 32'd1 << size;
    total = 32'(len + 1) * bytes;
    al    = start & ~(bytes - 32'd1);
    if (i == 0 || burst == 0) return start;
    if (burst == 2) begin
      lower = start & ~(total - 32'd1);
      return lower + ((al - lower + 32'(i) * bytes) % total);
    end
    return al + 32'(i) * bytes;
  endfunction

  function automatic bit beat_bad(input logic [31:0] a, input int size, input int len, input int burst);
`ifdef AXI4_RD_SEQ_SLVERR_EN
    bit bb;
    bb = (burst == 3) || (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15)) || (size > 2);
    return bb || (a >= MB);
`else
    return 1'b0;
`endif
  endfunction

  // Scoreboard side effects happen before the request so the monitor always finds them queued.
  task automatic send_ar(input logic [31:0] a, input logic [3:0] id, input int len, input int size,
                         input int burst);
    bit done;
    for (int i = 0; i <= len; i++) begin
      logic [31:0] ba;
      bit bad;
      ba  = beat_addr(a, size, len, burst, i);
      bad = beat_bad(ba, size, len, burst);
      if (!bad) addr_q.push_back(ba);
      exp_q.push_back('{bad ? 32'd0 : mem_word(ba), id, bad ? 2'b10 : 2'b00, (i == len)});
    end
    @(posedge clk);
    #1;
    arvalid = 1'b1; araddr = a; arid = id; arlen = 8'(len); arsize = 3'(size); arburst = 2'(burst);
    done = 0;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (arready) begin
        hs_cyc = cyc;
        if (want_lat) lat_chk = 1;
        done = 1;
        @(posedge clk);
        #1 arvalid = 1'b0;
      end
    end
    if (!done) begin
      check_val("ar_handshake_timeout", 0, 1);
      arvalid = 1'b0;
    end
  endtask

  task automatic drain(input int budget);
    bit done;
    done = 0;
    for (int k = 0; k < budget && !done; k++) begin
      @(posedge clk);
      #1;
      if (rnd_rdy) rready = 1'($urandom_range(0, 1));
      if (exp_q.size() == 0) done = 1;
    end
    if (!done) check_val("drain_timeout", 64'(exp_q.size()), 0);
    rready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (arr_chk) begin
        check_val("arready_after_rlast", arready, 1);
        arr_chk = 0;
      end
      if (mem_re) begin
        mre_cnt++;
        if (addr_q.size() == 0) check_val("mem_re_unexpected", 1, 0);
        else check_val("mem_addr", mem_addr, addr_q.pop_front());
      end
      if (rvalid && lat_chk) begin
        check_val("first_rvalid_latency", 64'(cyc - hs_cyc), 3);
        lat_chk = 0;
      end
      if (rvalid && rready) begin
        if (exp_q.size() == 0) check_val("rvalid_unexpected", 1, 0);
        else begin
          beat_t e;
          e = exp_q.pop_front();
          check_val("rdata", rdata, e.data);
          check_val("rid", rid, e.id);
          check_val("rresp", rresp, e.resp);
          check_val("rlast", rlast, e.last);
          if (rlast) arr_chk = 1;
        end
      end
    end
  end

  initial begin
    bit seen;
    repeat (3) @(negedge clk);
    check_val("rst_arready", arready, 0);
    check_val("rst_rvalid", rvalid, 0);
    check_val("rst_mem_re", mem_re, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_rlast", rlast, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check_val("arready_release_same_cycle", arready, 0);
    @(negedge clk);
    check_val("arready_release_next_cycle", arready, 1);

    rready = 1'b1;
    want_lat = 1;
    send_ar(32'h100, 4'h1, 3, 2, 1);
    want_lat = 0;
    check_val("busy_in_burst", busy, 1);
    drain(100);

    send_ar(32'h38, 4'h2, 3, 2, 2);
    drain(100);

    rready = 1'b0;
    mre_cnt = 0;
    send_ar(32'h20, 4'h3, 2, 2, 0);
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (rvalid) seen = 1;
    end
    check_val("stall_first_rvalid_seen", seen, 1);
    repeat (5) begin
      @(negedge clk);
      check_val("stall_rvalid", rvalid, 1);
      if (exp_q.size() != 0) check_val("stall_rdata", rdata, exp_q[0].data);
    end
    check_val("stall_mem_re_count", 64'(mre_cnt), 2);
    @(posedge clk);
    #1 rready = 1'b1;
    drain(100);

    send_ar(32'h40, 4'hA, 0, 2, 1);
    drain(100);

    send_ar(32'h200, 4'h5, 7, 2, 1);
    seen = 0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() <= 6) seen = 1;
    end
    check_val("reset_point_reached", seen, 1);
    rst = 1'b0;
    #1;
    check_val("midrst_rvalid", rvalid, 0);
    check_val("midrst_mem_re", mem_re, 0);
    check_val("midrst_busy", busy, 0);
    exp_q.delete();
    addr_q.delete();
    arr_chk = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    send_ar(32'h300, 4'h6, 1, 2, 1);
    drain(100);

    send_ar(32'(MB - 4), 4'h7, 1, 2, 1);
    drain(100);

    rnd_rdy = 1;
    for (int n = 0; n < 8; n++) begin
      int bt, ln, sz;
      logic [31:0] a;
      bt = $urandom_range(0, 2);
      sz = $urandom_range(0, 2);
      ln = (bt == 2) ? (2 << $urandom_range(0, 2)) - 1 : $urandom_range(0, 7);
      a  = 32'($urandom_range(0, 32'h7FF));
      if (bt == 2) a = a & ~((32'd1 << sz) - 32'd1);
      send_ar(a, 4'(n), ln, sz, bt);
      drain(300);
    end
    rnd_rdy = 0;

    check_val("final_exp_empty", 64'(exp_q.size()), 0);
    check_val("final_addr_empty", 64'(addr_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
